// File: rtl/led_pwm_bank.sv
// led_pwm_bank: a bank of CH LED PWM channels that share one period counter.
// A prescaler divides clk into PWM ticks. An optional per-channel phase
// stagger spreads the channels' on-windows across the period. New duties go
// through a shadow register and reach the channels only at a period wrap, so
// an output never glitches in the middle of a period.
module led_pwm_bank #(
  parameter int CH         = 4,
  parameter int DW         = 8,
  parameter int PRESCALE   = 1,
  parameter int ACTIVE_LOW = 1,
  parameter int STAGGER    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CH*DW-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic [CH-1:0]    pwm_out,
  output logic             period_start
);

  // Prescaler width; a single bit is kept even when PRESCALE is 1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DUTY_MAX = '1;
  // Pin level that means "LED off".
  localparam logic OFF_LVL = (ACTIVE_LOW != 0);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Phase offset of channel i: i * 2^DW / CH, truncated to DW bits.
  function automatic logic [DW-1:0] phase_offset(input int i);
    if (STAGGER == 0) begin
      return '0;
    end
    return DW'((longint'(i) << DW) / longint'(CH));
  endfunction

  // Compare one channel's phase with its duty. Full-scale duty is forced to
  // 100% on, so the single phase where ph == 2^DW-1 does not blip off.
  function automatic logic chan_on(input logic [DW-1:0] ph,
                                   input logic [DW-1:0] duty);
    if (duty == DUTY_MAX) begin
      return 1'b1;
    end
    if (duty == '0) begin
      return 1'b0;
    end
    return (ph < duty);
  endfunction

  logic [PW-1:0]    presc_q, presc_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             period_start_q, period_start_d;
  state_t           state_q, state_d;
  logic [CH*DW-1:0] shadow_q, shadow_d;
  logic [CH*DW-1:0] active_q, active_d;
  logic [CH-1:0]    pwm_q, pwm_d;
  logic             tick;
  logic             wrap;

  // Prescaler and period counter: both parked at zero while disabled.
  always_comb begin
    tick           = 1'b0;
    wrap           = 1'b0;
    presc_d        = '0;
    cnt_d          = '0;
    period_start_d = 1'b0;
    if (enable) begin
      tick    = (presc_q == PSC_LAST);
      presc_d = tick ? '0 : presc_q + 1'b1;
      cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
      wrap    = tick && (cnt_q == DUTY_MAX);
    end
    period_start_d = wrap;
  end

  // Duty update FSM: capture into shadow in IDLE, then promote shadow to the
  // active set at the next wrap. Disabling promotes at once, because no wrap
  // will arrive while the counter is held at zero.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (duty_valid) begin
          shadow_d = duty_in;
          state_d  = PENDING;
        end
      end
      PENDING: begin
        if (!enable || wrap) begin
          active_d = shadow_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-channel compare against the current count. The result is registered
  // so each pin comes straight off a flop.
  always_comb begin
    pwm_d = {CH{OFF_LVL}};
    if (enable) begin
      for (int i = 0; i < CH; i++) begin
        pwm_d[i] = chan_on(cnt_q + phase_offset(i), active_q[i*DW +: DW])
                   ? ~OFF_LVL : OFF_LVL;
      end
    end
  end

  // Counter, period_start and FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
      state_q        <= IDLE;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
      state_q        <= state_d;
    end
  end

  // Duty registers and output pins. Reset drops any pending update and
  // forces every LED off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= {CH{OFF_LVL}};
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign duty_ready   = (state_q == IDLE);
  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_led_pwm_bank.sv
// tb_led_pwm_bank: drives two led_pwm_bank instances. Instance A uses the
// defaults (4 ch, 8 bit, no prescale, active low, staggered). Instance B is
// 2 ch, 4 bit, prescale 3, active high, staggered. Both instances share the
// same control inputs. A behavioural model written in tick arithmetic
// predicts every output on every cycle. Table rows and hand-written
// sequences add checks against fixed expected values.
`timescale 1ns/1ps
module tb_led_pwm_bank;
  localparam int A_CH = 4, A_DW = 8, A_P = 1, A_AL = 1, A_ST = 1;
  localparam int B_CH = 2, B_DW = 4, B_P = 3, B_AL = 0, B_ST = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic duty_valid = 1'b0;
  logic [A_CH*A_DW-1:0] duty_a = '0;
  logic [B_CH*B_DW-1:0] duty_b = '0;
  logic rdy_a, ps_a, rdy_b, ps_b;
  logic [A_CH-1:0] pwm_a;
  logic [B_CH-1:0] pwm_b;

  int n_chk = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  led_pwm_bank #(.CH(A_CH), .DW(A_DW), .PRESCALE(A_P), .ACTIVE_LOW(A_AL), .STAGGER(A_ST)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .duty_in(duty_a), .duty_valid(duty_valid),
    .duty_ready(rdy_a), .pwm_out(pwm_a), .period_start(ps_a));

  led_pwm_bank #(.CH(B_CH), .DW(B_DW), .PRESCALE(B_P), .ACTIVE_LOW(B_AL), .STAGGER(B_ST)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .duty_in(duty_b), .duty_valid(duty_valid),
    .duty_ready(rdy_b), .pwm_out(pwm_b), .period_start(ps_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int p_n(input int d);  return (d == 0) ? (1 << A_DW) : (1 << B_DW); endfunction
  function automatic int p_p(input int d);  return (d == 0) ? A_P : B_P; endfunction
  function automatic int p_ch(input int d); return (d == 0) ? A_CH : B_CH; endfunction
  function automatic int p_al(input int d); return (d == 0) ? A_AL : B_AL; endfunction
  function automatic int p_st(input int d); return (d == 0) ? A_ST : B_ST; endfunction

  // m_cyc: enabled clock cycles since the last restart, modulo one period.
  int m_cyc[2];
  bit m_pend[2];
  int m_sh[2][4];
  int m_act[2][4];
  logic [5:0] e_vec[2];   // {ready, period_start, pwm[3:0]}

  function automatic bit ref_on(input int ph, input int duty, input int n);
    if (duty == n - 1) return 1'b1;
    if (duty == 0) return 1'b0;
    return ph < duty;
  endfunction

  function automatic int duty_field(input int d, input int ch);
    if (d == 0) return int'(duty_a[ch*A_DW +: A_DW]);
    return int'(duty_b[ch*B_DW +: B_DW]);
  endfunction

  task automatic model_reset(input int d);
    logic [3:0] pw;
    pw = '0;
    m_cyc[d] = 0;
    m_pend[d] = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      m_sh[d][ch] = 0;
      m_act[d][ch] = 0;
    end
    for (int ch = 0; ch < p_ch(d); ch++) pw[ch] = (p_al(d) != 0);
    e_vec[d] = {1'b1, 1'b0, pw};
  endtask

  task automatic model_step(input int d);
    int n, p, cnt, off, ph;
    bit wrap, on;
    logic [3:0] pw;
    n = p_n(d);
    p = p_p(d);
    cnt = enable ? (m_cyc[d] / p) % n : 0;
    wrap = enable && (((m_cyc[d] + 1) % (p * n)) == 0);
    pw = '0;
    for (int ch = 0; ch < p_ch(d); ch++) begin
      off = (p_st(d) != 0) ? (ch * n) / p_ch(d) : 0;
      ph = (cnt + off) % n;
      on = enable && ref_on(ph, m_act[d][ch], n);
      pw[ch] = (p_al(d) != 0) ? !on : on;
    end
    if (!m_pend[d]) begin
      if (duty_valid) begin
        for (int ch = 0; ch < p_ch(d); ch++) m_sh[d][ch] = duty_field(d, ch);
        m_pend[d] = 1'b1;
      end
    end else if (!enable || wrap) begin
      for (int ch = 0; ch < 4; ch++) m_act[d][ch] = m_sh[d][ch];
      m_pend[d] = 1'b0;
    end
    m_cyc[d] = enable ? (m_cyc[d] + 1) % (p * n) : 0;
    e_vec[d] = {!m_pend[d], wrap, pw};
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_a", {26'd0, rdy_a, ps_a, pwm_a}, {26'd0, e_vec[0]});
      check("model_b", {26'd0, rdy_b, ps_b, 2'b00, pwm_b}, {26'd0, e_vec[1]});
    end
  end

  // ---------------- helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all(input logic [7:0] v);
    int k;
    k = 0;
    while (rdy_a !== 1'b1 && k < 1000) begin
      cyc();
      k++;
    end
    check("load_ready", (k < 1000), 1);
    duty_a = {4{v}};
    duty_b = 8'($urandom);
    duty_valid = 1'b1;
    cyc();
    duty_valid = 1'b0;
  endtask

  task automatic wait_ready_a(input int limit, output int k);
    k = 0;
    for (int j = 1; j <= limit; j++) begin
      @(negedge clk);
      if (rdy_a === 1'b1) begin
        k = j;
        return;
      end
    end
  endtask

  typedef struct packed {
    int duty;
    int periods;
    int exp_on;
  } row_t;

  row_t tbl[6];

  initial begin
    int k, cnt_on, cnt3, cnt_ps, t0, tr;
    logic [3:0] hist[512];
    logic [7:0] r8;

    tbl[0] = '{duty: 64,  periods: 1, exp_on: 64};
    tbl[1] = '{duty: 0,   periods: 3, exp_on: 0};
    tbl[2] = '{duty: 255, periods: 3, exp_on: 256};
    tbl[3] = '{duty: 1,   periods: 1, exp_on: 1};
    tbl[4] = '{duty: 128, periods: 1, exp_on: 128};
    tbl[5] = '{duty: 254, periods: 1, exp_on: 254};

    // Reset takes effect without a clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_pwm_a", pwm_a, 4'hF);
    check("rst_rdy_a", rdy_a, 1);
    check("rst_ps_a", ps_a, 0);
    check("rst_pwm_b", pwm_b, 2'b00);
    check("rst_rdy_b", rdy_b, 1);
    cyc();
    rst = 1'b0;
    enable = 1'b1;
    chk_on = 1'b1;

    // Table: uniform duty on all channels, on-time counted over whole periods.
    for (int r = 0; r < 6; r++) begin
      int on_n[4];
      r8 = tbl[r].duty[7:0];
      load_all(r8);
      wait_ready_a(600, k);
      check($sformatf("tbl%0d_applied", r), (k != 0), 1);
      check($sformatf("tbl%0d_ps_at_apply", r), ps_a, 1);
      cnt_ps = 0;
      for (int ch = 0; ch < 4; ch++) on_n[ch] = 0;
      for (int j = 0; j < 256 * tbl[r].periods; j++) begin
        @(negedge clk);
        if (ps_a === 1'b1) cnt_ps++;
        for (int ch = 0; ch < 4; ch++) if (pwm_a[ch] === 1'b0) on_n[ch]++;
      end
      for (int ch = 0; ch < 4; ch++)
        check($sformatf("tbl%0d_on_ch%0d", r, ch), on_n[ch], tbl[r].exp_on * tbl[r].periods);
      check($sformatf("tbl%0d_ps_count", r), cnt_ps, tbl[r].periods);
    end

    // Stagger: duty 128, rising edges of ch1..3 relative to ch0.
    load_all(8'd128);
    wait_ready_a(600, k);
    check("stg_applied", (k != 0), 1);
    for (int j = 0; j < 512; j++) begin
      @(negedge clk);
      hist[j] = pwm_a;
    end
    t0 = -1;
    for (int j = 1; j < 512; j++)
      if (t0 < 0 && hist[j-1][0] == 1'b1 && hist[j][0] == 1'b0) t0 = j;
    check("stg_ch0_rise_found", (t0 >= 0), 1);
    for (int ch = 1; ch < 4; ch++) begin
      tr = -1;
      for (int j = 1; j < 512; j++)
        if (tr < 0 && j > t0 && hist[j-1][ch] == 1'b1 && hist[j][ch] == 1'b0) tr = j;
      check($sformatf("stg_delta_ch%0d", ch), tr - t0, 256 - 64 * ch);
    end

    // Handshake at cnt=10, second valid while pending is ignored.
    cyc();
    k = 0;
    while (m_cyc[0] != 10 && k < 600) begin
      cyc();
      k++;
    end
    check("hs_found_cnt10", (k < 600), 1);
    duty_a = {4{8'd40}};
    duty_valid = 1'b1;
    cyc();
    duty_a = {4{8'd200}};
    @(negedge clk);
    check("hs_ready_drop", rdy_a, 0);
    repeat (5) cyc();
    duty_valid = 1'b0;
    wait_ready_a(400, k);
    check("hs_ready_return_cycles", 5 + k, 246);
    check("hs_ps_with_ready", ps_a, 1);
    cnt_on = 0;
    cnt3 = 0;
    for (int j = 0; j < 256; j++) begin
      @(negedge clk);
      if (pwm_a[0] === 1'b0) cnt_on++;
      if (pwm_a[3] === 1'b0) cnt3++;
    end
    check("hs_first_duty_ch0", cnt_on, 40);
    check("hs_first_duty_ch3", cnt3, 40);

    // Valid coincident with the wrap tick: applies one full period later.
    cyc();
    k = 0;
    while (m_cyc[0] != 255 && k < 600) begin
      cyc();
      k++;
    end
    check("wr_found_cnt255", (k < 600), 1);
    duty_a = {4{8'd100}};
    duty_valid = 1'b1;
    cyc();
    duty_valid = 1'b0;
    cnt_on = 0;
    tr = 0;
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk);
      if (j == 1) begin
        check("wr_ps_now", ps_a, 1);
        check("wr_ready_low", rdy_a, 0);
      end
      if (pwm_a[0] === 1'b0) cnt_on++;
      if (rdy_a === 1'b1) begin
        tr = j;
        break;
      end
    end
    check("wr_ready_after", tr, 257);
    check("wr_old_duty_kept", cnt_on, 40);
    cnt_on = 0;
    for (int j = 0; j < 256; j++) begin
      @(negedge clk);
      if (pwm_a[0] === 1'b0) cnt_on++;
    end
    check("wr_new_duty", cnt_on, 100);

    // Reset for one cycle while an update is pending.
    load_all(8'd200);
    repeat (30) cyc();
    check("rp_pending", rdy_a, 0);
    rst = 1'b1;
    #1;
    check("rp_pwm_off", pwm_a, 4'hF);
    check("rp_ready", rdy_a, 1);
    check("rp_ps", ps_a, 0);
    cyc();
    rst = 1'b0;
    cnt_on = 0;
    for (int j = 0; j < 600; j++) begin
      @(negedge clk);
      for (int ch = 0; ch < 4; ch++) if (pwm_a[ch] === 1'b0) cnt_on++;
    end
    check("rp_duties_zero", cnt_on, 0);

    // Disable mid-period with an update pending, then re-enable.
    load_all(8'd255);
    wait_ready_a(600, k);
    check("en_full_applied", (k != 0), 1);
    load_all(8'd50);
    repeat (20) cyc();
    check("en_on_before", pwm_a, 4'h0);
    enable = 1'b0;
    cyc();
    check("en_off_next", pwm_a, 4'hF);
    check("en_ready_now", rdy_a, 1);
    cnt_ps = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (ps_a === 1'b1) cnt_ps++;
    end
    check("en_no_ps_while_off", cnt_ps, 0);
    cyc();
    enable = 1'b1;
    cnt_on = 0;
    tr = 0;
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk);
      if (j >= 2 && pwm_a[0] === 1'b0) cnt_on++;
      if (ps_a === 1'b1) begin
        tr = j;
        break;
      end
    end
    check("en_first_ps", tr, 257);
    check("en_pending_visible", cnt_on, 50);

    // Randomized traffic against the model.
    for (int c = 0; c < 6000; c++) begin
      cyc();
      rst = ($urandom_range(0, 999) == 0);
      duty_valid = ($urandom_range(0, 99) < 8);
      if (duty_valid) begin
        for (int ch = 0; ch < 4; ch++) begin
          case ($urandom_range(0, 5))
            0: r8 = 8'd0;
            1: r8 = 8'd255;
            default: r8 = 8'($urandom_range(0, 255));
          endcase
          duty_a[ch*8 +: 8] = r8;
        end
        duty_b = 8'($urandom);
      end
      if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
    end
    rst = 1'b0;
    duty_valid = 1'b0;
    cyc();
    cyc();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/led_pwm_bank.md
LED_PWM_BANK -- requirements
Module: led_pwm_bank

Interface
REQ-001 Parameter CH, default 4: number of PWM channels.
REQ-002 Parameter DW, default 8: duty width in bits; PWM period is 2^DW ticks.
REQ-003 Parameter PRESCALE, default 1: clk cycles per PWM tick; legal range 1..65535.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 = output low means LED on.
REQ-005 Parameter STAGGER, default 1: 1 = channel i phase-offset by i*2^DW/CH ticks.
REQ-006 clk  in  1  single system clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 enable  in  1  1 = PWM running; 0 = outputs off, counters held.
REQ-009 duty_in  in  CH*DW  packed duties, channel i at bits [i*DW +: DW].
REQ-010 duty_valid  in  1  duty_in offered this cycle.
REQ-011 duty_ready  out  1  block can accept duty_in this cycle.
REQ-012 pwm_out  out  CH  per-channel PWM, polarity per ACTIVE_LOW.
REQ-013 period_start  out  1  one-cycle pulse at each period wrap.

Function
REQ-014 Prescaler SHALL count 0..PRESCALE-1 and assert an internal tick for one cycle when it wraps to 0.
REQ-015 Period counter cnt (DW bits) SHALL advance by 1 on each tick, wrapping 2^DW-1 -> 0.
REQ-016 period_start SHALL pulse for exactly the cycle following the tick on which cnt wraps to 0.
REQ-017 Channel phase SHALL be ph_i = (cnt + (STAGGER ? i*2^DW/CH : 0)) mod 2^DW; additions truncate to DW bits.
REQ-018 Channel i SHALL be logically on when ph_i < active_duty_i, except that duty 2^DW-1 SHALL be on for all phases (100%) and duty 0 SHALL be off for all phases.
REQ-019 pwm_out SHALL be registered: one cycle of latency from cnt/duty to pin; on maps to 0 when ACTIVE_LOW=1, else 1.
REQ-020 Update FSM states: IDLE (duty_ready=1) and PENDING (duty_ready=0).
REQ-021 IDLE: duty_valid=1 SHALL capture duty_in into shadow registers and move to PENDING on the same edge.
REQ-022 PENDING: at the tick where cnt wraps to 0, shadow SHALL copy to active duties, and the FSM SHALL return to IDLE; duty_ready is 1 the following cycle.
REQ-023 Active duties SHALL change only at a period wrap, or per REQ-025; no mid-period glitch.
REQ-024 duty_valid while duty_ready=0 SHALL be ignored; no data is lost and no data is overwritten.
REQ-025 enable=0 SHALL hold prescaler and cnt at 0, drive pwm_out to the off level on the next edge, and, if PENDING, apply shadow to active immediately and return to IDLE.
REQ-026 enable 0->1 SHALL restart from cnt=0; the first period_start occurs after 2^DW ticks.
REQ-027 Simultaneous handshake in IDLE and period wrap: capture SHALL occur, and the new duty SHALL apply at the next wrap, not the current one.
REQ-028 period_start SHALL not pulse while enable=0.

Reset
REQ-029 rst=1 SHALL immediately set: prescaler=0, cnt=0, active and shadow duties=0, FSM=IDLE, duty_ready=1, period_start=0, pwm_out=all off level ({CH{1}} when ACTIVE_LOW=1).
REQ-030 Reset asserted mid-period or in PENDING SHALL discard the pending update.
REQ-031 Reset release SHALL be synchronous to clk; the first tick occurs PRESCALE cycles after release when enable=1.

Verification
REQ-032 DW=8, PRESCALE=1, CH=4, STAGGER=0: load duty 64 on all channels -> after wrap, each channel on 64 of 256 cycles; period_start every 256 cycles.
REQ-033 Duty 0 and duty 255 -> channel constantly off and constantly on across 3 full periods; no single-cycle glitches.
REQ-034 STAGGER=1, duty 128: channel on-windows start at phase offsets of 0, 64, 128, and 192 ticks -> the rising edges of channels 1..3 occur 192, 128, and 64 cycles after channel 0's.
REQ-035 Handshake: valid at cnt=10 -> ready drops the next cycle, duty applies at the cnt wrap, ready=1 the cycle after; a second valid during PENDING is ignored.
REQ-036 Valid coincident with wrap tick -> new duty takes effect one full period later (REQ-027).
REQ-037 Assert rst for 1 cycle mid-period in PENDING -> outputs off, ready=1, duties 0; enable=0 mid-period -> outputs off next cycle, pending duty visible after re-enable.
